// File: rtl/updown_counter_pkg.sv
// Shared constants, config register layout and wrap helper for the up/down counter.
package updown_counter_pkg;

  localparam int unsigned COUNT_W              = 32;
  localparam int unsigned LT_THRESHOLD_DEFAULT = 1000;
  localparam int unsigned PRESCALE_DEFAULT     = 4;
  localparam int unsigned PRESCALE_MAX         = 65535;
  localparam int unsigned PHASE_W              = 16;

  typedef struct packed {
    logic en;
    logic dir;  // 1 = count up
    logic ire;
  } cfg_t;

  localparam logic [COUNT_W-1:0] RST_COUNT = '0;
  localparam cfg_t               RST_CFG   = '{en: 1'b0, dir: 1'b1, ire: 1'b0};
  localparam logic               RST_IRQ   = 1'b0;

  // A step wraps when it leaves the top going up or the bottom going down.
  function automatic logic step_wraps(input logic [COUNT_W-1:0] count, input logic dir);
    return dir ? (count == {COUNT_W{1'b1}}) : (count == '0);
  endfunction

endpackage

// File: rtl/updown_counter_core_prescaler.sv
// Count-tick divider: tick pulses once every PRESCALE enabled cycles, phase restarts on demand.
module counter_prescaler
  import updown_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PRESCALE - 1);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  assign tick = en && (phase_q == LAST_PHASE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
    if (restart || !en || tick) phase_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/updown_counter_core.sv
// 32-bit up/down counter with config register, wrap interrupt and below-threshold status.
// Optional count-tick prescaler is compiled in with macro COUNTER_PRESCALER_EN.
module updown_counter_core
  import updown_counter_pkg::*;
#(
  parameter logic [COUNT_W-1:0] LT_THRESHOLD = LT_THRESHOLD_DEFAULT,
  parameter int unsigned        PRESCALE     = PRESCALE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               count_we,
  input  logic               config_we,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               en_in,
  input  logic               dir_in,
  input  logic               ire_in,
  input  logic               irq_clr,
  output logic [COUNT_W-1:0] count_out,
  output logic               en_out,
  output logic               dir_out,
  output logic               ire_out,
  output logic               lt_1k_out,
  output logic               irq_out
);

  if (PRESCALE < 1 || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("updown_counter_core: PRESCALE must be in 1..65535");
  end

  logic [COUNT_W-1:0] count_q, count_d;
  cfg_t               cfg_q, cfg_d;
  logic               irq_q, irq_d;
  logic               tick;
  logic               step;
  logic               wrap;

`ifdef COUNTER_PRESCALER_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (count_we | config_we),
    .en      (cfg_q.en),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Steps use the config held before any same-cycle config write; a load beats a step.
  assign step = cfg_q.en & tick & ~count_we;
  assign wrap = step & step_wraps(count_q, cfg_q.dir);

  always_comb begin
    count_d = count_q;
    cfg_d   = cfg_q;
    irq_d   = irq_q;

    if (count_we)  count_d = count_in;
    else if (step) count_d = cfg_q.dir ? count_q + COUNT_W'(1) : count_q - COUNT_W'(1);

    if (config_we) cfg_d = '{en: en_in, dir: dir_in, ire: ire_in};

    // A fresh wrap with interrupts enabled outranks every clear source.
    if (wrap && cfg_q.ire)                       irq_d = 1'b1;
    else if (irq_clr || (config_we && !ire_in)) irq_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_COUNT;
      cfg_q   <= RST_CFG;
      irq_q   <= RST_IRQ;
    end else begin
      count_q <= count_d;
      cfg_q   <= cfg_d;
      irq_q   <= irq_d;
    end
  end

  assign count_out = count_q;
  assign en_out    = cfg_q.en;
  assign dir_out   = cfg_q.dir;
  assign ire_out   = cfg_q.ire;
  assign irq_out   = irq_q;
  assign lt_1k_out = (count_q < LT_THRESHOLD);

endmodule

// File: tb/tb_updown_counter_core.sv
// Self-checking bench for updown_counter_core: directed scenarios plus random traffic vs a behavioural model.
module tb_updown_counter_core;

  localparam int unsigned TB_PRESCALE = 4;
`ifdef COUNTER_PRESCALER_EN
  localparam int unsigned MODEL_P = TB_PRESCALE;
`else
  localparam int unsigned MODEL_P = 1;
`endif
  localparam longint LT = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0, count_we = 1'b0, config_we = 1'b0;
  logic [31:0] count_in = '0;
  logic        en_in = 1'b0, dir_in = 1'b0, ire_in = 1'b0, irq_clr = 1'b0;
  logic [31:0] count_out;
  logic        en_out, dir_out, ire_out, lt_1k_out, irq_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  longint m_count = 0;
  bit     m_en = 0, m_dir = 1, m_ire = 0, m_irq = 0;
  int     m_since = 0;

  always #5 clk = ~clk;

  updown_counter_core #(
    .LT_THRESHOLD (32'd1000),
    .PRESCALE     (TB_PRESCALE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .count_we  (count_we),
    .config_we (config_we),
    .count_in  (count_in),
    .en_in     (en_in),
    .dir_in    (dir_in),
    .ire_in    (ire_in),
    .irq_clr   (irq_clr),
    .count_out (count_out),
    .en_out    (en_out),
    .dir_out   (dir_out),
    .ire_out   (ire_out),
    .lt_1k_out (lt_1k_out),
    .irq_out   (irq_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit rst, input bit cwe, input bit cfgwe, input logic [31:0] cin,
                        input bit en, input bit dir, input bit ire, input bit clr);
    reset = rst; count_we = cwe; config_we = cfgwe; count_in = cin;
    en_in = en; dir_in = dir; ire_in = ire; irq_clr = clr;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 32'd0, 0, 0, 0, 0);
  endtask

  // Advance one clock; the model predicts from the inputs applied before the edge.
  task automatic cycle(input bit check_model = 1'b1);
    longint n_count, sum;
    bit     n_en, n_dir, n_ire, n_irq, tk, stepping, wrap;
    int     n_since;
    if (reset) begin
      n_count = 0; n_en = 0; n_dir = 1; n_ire = 0; n_irq = 0; n_since = 0;
    end else begin
      tk       = m_en && (((m_since + 1) % MODEL_P) == 0);
      stepping = m_en && tk && !count_we;
      wrap     = 0;
      n_count  = m_count;
      if (count_we) n_count = longint'(count_in);
      else if (stepping) begin
        sum     = m_count + (m_dir ? 1 : -1);
        wrap    = (sum < 0) || (sum >= 64'sd4294967296);
        n_count = sum & 64'h0000_0000_FFFF_FFFF;
      end
      n_irq = m_irq;
      if (wrap && m_ire) n_irq = 1;
      else if (irq_clr || (config_we && !ire_in)) n_irq = 0;
      n_since = (count_we || config_we || !m_en) ? 0 : m_since + 1;
      {n_en, n_dir, n_ire} = config_we ? {en_in, dir_in, ire_in} : {m_en, m_dir, m_ire};
    end
    @(posedge clk);
    #1;
    m_count = n_count; m_en = n_en; m_dir = n_dir; m_ire = n_ire; m_irq = n_irq; m_since = n_since;
    if (check_model) begin
      check("model_count", count_out, m_count[31:0]);
      check("model_cfg", {29'd0, en_out, dir_out, ire_out}, {29'd0, m_en, m_dir, m_ire});
      check("model_irq", {31'd0, irq_out}, {31'd0, m_irq});
      check("model_lt", {31'd0, lt_1k_out}, {31'd0, (m_count < LT)});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, count_out, 32'd0);
    check({tag, "_cfg"}, {29'd0, en_out, dir_out, ire_out}, 32'b010);
    check({tag, "_irq"}, {31'd0, irq_out}, 32'd0);
    check({tag, "_lt"}, {31'd0, lt_1k_out}, 32'd1);
  endtask

  initial begin
    set_in(1, 0, 0, 32'd0, 0, 0, 0, 0);
    cycle(); cycle();
    check_reset_state("reset");

`ifndef COUNTER_PRESCALER_EN
    // Five enabled up-steps from zero.
    set_in(0, 0, 1, 32'd0, 1, 1, 0, 0); cycle();
    idle(); repeat (5) cycle();
    check("up5_count", count_out, 32'd5);
    check("up5_lt", {31'd0, lt_1k_out}, 32'd1);

    // Wrap going up raises irq on the wrapping edge.
    set_in(0, 1, 1, 32'hFFFF_FFFE, 1, 1, 1, 0); cycle();
    check("upwrap_load", count_out, 32'hFFFF_FFFE);
    idle(); cycle();
    check("upwrap_max", count_out, 32'hFFFF_FFFF);
    check("upwrap_noirq", {31'd0, irq_out}, 32'd0);
    cycle();
    check("upwrap_zero", count_out, 32'd0);
    check("upwrap_irq", {31'd0, irq_out}, 32'd1);

    // Wrap going down; clear colliding with a new wrap loses.
    set_in(0, 1, 1, 32'd0, 1, 0, 1, 1); cycle();
    check("dn_load_zero", count_out, 32'd0);
    check("dn_cleared", {31'd0, irq_out}, 32'd0);
    idle(); cycle();
    check("dnwrap_count", count_out, 32'hFFFF_FFFF);
    check("dnwrap_irq", {31'd0, irq_out}, 32'd1);
    set_in(0, 1, 0, 32'd0, 0, 0, 0, 0); cycle();
    check("load_no_wrap", count_out, 32'd0);
    set_in(0, 0, 0, 32'd0, 0, 0, 0, 1); cycle();
    check("clr_vs_wrap_count", count_out, 32'hFFFF_FFFF);
    check("clr_vs_wrap_irq", {31'd0, irq_out}, 32'd1);
    cycle();
    check("clr_alone_irq", {31'd0, irq_out}, 32'd0);
    check("clr_alone_count", count_out, 32'hFFFF_FFFE);

    // Threshold edge: 999 -> 1000; config write with ire=0 also drops irq.
    set_in(0, 1, 1, 32'd999, 1, 1, 0, 0); cycle();
    check("lt_999", {31'd0, lt_1k_out}, 32'd1);
    idle(); cycle();
    check("lt_1000_count", count_out, 32'd1000);
    check("lt_1000", {31'd0, lt_1k_out}, 32'd0);

    // Load beats step, then reset overrides everything mid-run with irq pending.
    set_in(0, 1, 0, 32'd7, 0, 0, 0, 0); cycle();
    check("load_7", count_out, 32'd7);
    idle(); repeat (3) cycle();
    check("after_load_steps", count_out, 32'd10);
    set_in(0, 1, 1, 32'hFFFF_FFFF, 1, 1, 1, 0); cycle();
    idle(); cycle();
    check("pre_reset_irq", {31'd0, irq_out}, 32'd1);
    set_in(1, 1, 1, 32'd123, 1, 0, 1, 0); cycle();
    check_reset_state("midrun_reset");
`else
    // Divide-by-4: twelve enabled cycles give three steps.
    set_in(0, 0, 1, 32'd0, 1, 1, 0, 0); cycle();
    idle(); repeat (12) cycle();
    check("pre_12_count", count_out, 32'd3);
    repeat (2) cycle();
    set_in(0, 0, 1, 32'd0, 1, 1, 0, 0); cycle();
    idle(); repeat (3) cycle();
    check("pre_restart_hold", count_out, 32'd3);
    cycle();
    check("pre_restart_step", count_out, 32'd4);
    set_in(1, 0, 0, 32'd0, 0, 0, 0, 0); cycle();
    check_reset_state("pre_reset");
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] cin;
      case ($urandom_range(0, 7))
        0: cin = 32'd0;
        1: cin = 32'hFFFF_FFFF;
        2: cin = 32'hFFFF_FFFE;
        3: cin = 32'd1;
        4: cin = 32'd998;
        5: cin = 32'd999;
        6: cin = 32'd1000;
        default: cin = $urandom;
      endcase
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             cin, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
